// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-format encodings for the immediate generator
package imm_pkg;

  localparam int IMM_SRC_W = 3;

  // Format select codes; 101..111 are illegal.
  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction and sign extension
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  logic [31:0] imm32;

  // Build the 32-bit immediate; every legal format has instr[31] as its top bit.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: begin
        imm32   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN by replicating bit 31 (zero for an illegal select).
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with valid/ready handshake
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int DEPTH = 1,   // 1..4 register stages
  parameter int TAG_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  input  logic [IMM_SRC_W-1:0] i_imm_src,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_imm,
  output logic [TAG_W-1:0]     o_tag,
  output logic                 o_illegal
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } imm_stage_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [DEPTH:0]  ready;
  imm_stage_t      in_stage;
  imm_stage_t      last_q;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr   (i_instr),
    .imm_src (i_imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // A stage may load whenever it is empty or its successor is moving;
  // the chain ends at the downstream ready.
  assign ready[DEPTH] = i_ready;

  assign in_stage = '{
    valid:   i_valid & ready[0],
    imm:     dec_imm,
    tag:     i_tag,
    illegal: dec_illegal
  };

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    imm_stage_t q;
    imm_stage_t d;

    if (k == 0) begin : g_first
      assign d = in_stage;
    end else begin : g_next
      assign d = g_stage[k-1].q;
    end

    assign ready[k] = ~q.valid | ready[k+1];

    // Stage register: reset wins over flush; flush only kills the valid bit,
    // so an input offered alongside a flush never becomes visible.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q <= '0;
      end else begin
        if (ready[k]) begin
          q <= d;
        end
        if (i_flush) begin
          q.valid <= 1'b0;
        end
      end
    end
  end

  assign last_q    = g_stage[DEPTH-1].q;
  assign o_ready   = ready[0];
  assign o_valid   = last_q.valid;
  assign o_imm     = last_q.imm;
  assign o_tag     = last_q.tag;
  assign o_illegal = last_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [4:0]  tag = '0;

  logic        d1_ready, d1_valid, d1_illegal;
  logic [31:0] d1_imm;
  logic [4:0]  d1_tag;
  logic        d2_ready, d2_valid, d2_illegal;
  logic [31:0] d2_imm;
  logic [4:0]  d2_tag;
  logic        d3_ready, d3_valid, d3_illegal;
  logic [31:0] d3_imm;
  logic [4:0]  d3_tag;
  logic        w_ready, w_valid, w_illegal;
  logic [63:0] w_imm;
  logic [4:0]  w_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(1), .TAG_W(5)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(d1_ready),
    .i_instr(instr), .i_imm_src(imm_src), .i_tag(tag), .o_valid(d1_valid),
    .i_ready(out_ready), .o_imm(d1_imm), .o_tag(d1_tag), .o_illegal(d1_illegal));

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(d2_ready),
    .i_instr(instr), .i_imm_src(imm_src), .i_tag(tag), .o_valid(d2_valid),
    .i_ready(out_ready), .o_imm(d2_imm), .o_tag(d2_tag), .o_illegal(d2_illegal));

  imm_gen_pipe #(.XLEN(32), .DEPTH(3), .TAG_W(5)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(d3_ready),
    .i_instr(instr), .i_imm_src(imm_src), .i_tag(tag), .o_valid(d3_valid),
    .i_ready(out_ready), .o_imm(d3_imm), .o_tag(d3_tag), .o_illegal(d3_illegal));

  imm_gen_pipe #(.XLEN(64), .DEPTH(1), .TAG_W(5)) u_w (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(w_ready),
    .i_instr(instr), .i_imm_src(imm_src), .i_tag(tag), .o_valid(w_valid),
    .i_ready(out_ready), .o_imm(w_imm), .o_tag(w_tag), .o_illegal(w_illegal));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] t);
    in_valid = 1'b1;
    instr = ins;
    imm_src = src;
    tag = t;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (d1_valid !== 1'b0 || d1_imm !== 32'h0 || d1_tag !== 5'h0 || d1_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b imm=%h tag=%h ill=%b, expected all zero", d1_valid, d1_imm, d1_tag, d1_illegal);
    end
    checks++;
    if (d1_ready !== 1'b1 || d3_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got d1=%b d3=%b, expected 1", d1_ready, d3_ready);
    end
    checks++;
    if (w_imm !== 64'h0) begin
      errors++;
      $display("FAIL reset_imm64: got %h expected 0", w_imm);
    end
  endtask

  task automatic test_i_type();
    do_reset();
    drive(32'hFFF00093, 3'b000, 5'd5);
    tick();
    in_valid = 1'b0;
    checks++;
    if (d1_valid !== 1'b1 || d1_imm !== 32'hFFFFFFFF || d1_illegal !== 1'b0 || d1_tag !== 5'd5) begin
      errors++;
      $display("FAIL i_type: got v=%b imm=%h ill=%b tag=%0d, expected v=1 imm=ffffffff ill=0 tag=5", d1_valid, d1_imm, d1_illegal, d1_tag);
    end
    tick();
    checks++;
    if (d1_valid !== 1'b0) begin
      errors++;
      $display("FAIL i_type_bubble: got o_valid=%b expected 0", d1_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'h001000EF};
    logic [2:0]  src [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] exp [4] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], src[i], 5'(i));
      tick();
      checks++;
      if (d1_valid !== 1'b1 || d1_imm !== exp[i] || d1_tag !== 5'(i) || d1_illegal !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b imm=%h tag=%0d ill=%b, expected v=1 imm=%h tag=%0d ill=0", i, d1_valid, d1_imm, d1_tag, d1_illegal, exp[i], i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [4:0] got [$];
    logic acc;
    do_reset();
    out_ready = 1'b0;
    drive(32'h00500093, 3'b000, 5'd1);
    #1;
    checks++;
    if (d2_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept_a: got o_ready=%b expected 1", d2_ready);
    end
    tick();
    drive(32'h00600093, 3'b000, 5'd2);
    #1;
    checks++;
    if (d2_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_accept_b: got o_ready=%b expected 1", d2_ready);
    end
    tick();
    drive(32'h00700093, 3'b000, 5'd3);
    #1;
    checks++;
    if (d2_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: got o_ready=%b expected 0", d2_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (d2_valid !== 1'b1 || d2_imm !== 32'h5 || d2_tag !== 5'd1 || d2_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b imm=%h tag=%0d rdy=%b, expected v=1 imm=5 tag=1 rdy=0", c, d2_valid, d2_imm, d2_tag, d2_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (d2_valid) got.push_back(d2_tag);
      acc = in_valid && d2_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL stall_drain_count: got %0d entries expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 5'(i + 1)) begin
          errors++;
          $display("FAIL stall_drain_order_%0d: got tag %0d expected %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(32'hFFFFFFFF, 3'b110, 5'd7);
    tick();
    checks++;
    if (d1_valid !== 1'b1 || d1_imm !== 32'h0 || d1_illegal !== 1'b1 || d1_tag !== 5'd7) begin
      errors++;
      $display("FAIL illegal_src: got v=%b imm=%h ill=%b tag=%0d, expected v=1 imm=0 ill=1 tag=7", d1_valid, d1_imm, d1_illegal, d1_tag);
    end
    drive(32'h00100093, 3'b000, 5'd8);
    tick();
    in_valid = 1'b0;
    checks++;
    if (d1_valid !== 1'b1 || d1_imm !== 32'h1 || d1_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_then_legal: got v=%b imm=%h ill=%b, expected v=1 imm=1 ill=0", d1_valid, d1_imm, d1_illegal);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h00000093 | (32'(i + 1) << 20), 3'b000, 5'(i + 1));
      tick();
      checks++;
      if (d3_valid !== (i == 2)) begin
        errors++;
        $display("FAIL flush_latency_%0d: got o_valid=%b expected %b", i, d3_valid, (i == 2));
      end
    end
    checks++;
    if (d3_ready !== 1'b0 || d3_tag !== 5'd1 || d3_imm !== 32'h1) begin
      errors++;
      $display("FAIL flush_full: got rdy=%b tag=%0d imm=%h, expected rdy=0 tag=1 imm=1", d3_ready, d3_tag, d3_imm);
    end
    drive(32'h00900093, 3'b000, 5'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (d3_valid !== 1'b0 || d3_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got v=%b rdy=%b, expected v=0 rdy=1", d3_valid, d3_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (d3_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_leak_%0d: got o_valid=%b tag=%0d expected o_valid=0", c, d3_valid, d3_tag);
      end
    end
  endtask

  task automatic test_xlen64_reset();
    do_reset();
    drive(32'h800000B7, 3'b011, 5'd2);
    tick();
    checks++;
    if (w_valid !== 1'b1 || w_imm !== 64'hFFFFFFFF80000000 || w_illegal !== 1'b0) begin
      errors++;
      $display("FAIL u_xlen64: got v=%b imm=%h ill=%b, expected v=1 imm=ffffffff80000000 ill=0", w_valid, w_imm, w_illegal);
    end
    drive(32'hFFF00093, 3'b000, 5'd3);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (w_valid !== 1'b0 || w_imm !== 64'h0 || w_tag !== 5'h0 || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: got v=%b imm=%h tag=%0d rdy=%b, expected v=0 imm=0 tag=0 rdy=1", w_valid, w_imm, w_tag, w_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_i_type();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_xlen64_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
